// File: rtl/rv32e_pkg.sv
// rtl/rv32e_pkg.sv - shared constants and types for the rv32e fetch path
package rv32e_pkg;

    localparam int          XLEN           = 32;
    localparam logic [31:0] RV32E_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] RV32E_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/rv32e_instr_fifo.sv
// rtl/rv32e_instr_fifo.sv - generic synchronous FIFO with flush and occupancy count
module rv32e_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int              PW      = $clog2(DEPTH);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q,  count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/rv32e_fetch_buffer.sv
// rtl/rv32e_fetch_buffer.sv - instruction prefetch stage feeding rv32e decode
module rv32e_fetch_buffer
    import rv32e_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RV32E_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    output logic [XLEN-1:0]  mem_program_addr_bus,
    input  logic [XLEN-1:0]  mem_program_data_bus,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr_data,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            push, pop, full, empty;
    logic [CW-1:0]   count;
    fetch_entry_t    wr_entry, head;

    assign mem_program_addr_bus = fetch_pc_q;
    assign instr_valid          = (count != '0);

    // Redirect suppresses both sides of the queue in the cycle it is seen.
    assign pop  = instr_valid & instr_ready & ~redirect_valid;
    assign push = ~redirect_valid & (~full | pop);

    assign wr_entry.pc   = fetch_pc_q;
    assign wr_entry.data = mem_program_data_bus;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        else if (push)
            fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    rv32e_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign instr_data = empty ? RV32E_NOP : head.data;
    assign instr_pc   = empty ? '0        : head.pc;

endmodule

// File: tb/tb_rv32e_fetch_buffer.sv
// tb/tb_rv32e_fetch_buffer.sv - self-checking bench for rv32e_fetch_buffer
module tb_rv32e_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors;
    int checks;

    logic [63:0] mq[$];
    logic [31:0] m_pc;

    rv32e_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk                  (clk),
        .reset                (reset),
        .mem_program_addr_bus (addr),
        .mem_program_data_bus (rom_data),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .instr_data           (instr_data),
        .instr_pc             (instr_pc),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    assign rom_data = rom(addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the queue model advances alongside the DUT.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        bit do_pop, do_push;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        do_pop  = (mq.size() != 0) && rdy && !rv;
        do_push = !rv && ((mq.size() < DEPTH) || do_pop);
        @(posedge clk);
        if (rv) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_pc = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%0b exp=0", instr_valid);
        end
        checks++;
        if (instr_data !== NOP || instr_pc !== 32'h0) begin
            errors++; $display("FAIL reset_head got data=%h pc=%h exp data=%h pc=0", instr_data, instr_pc, NOP);
        end
        checks++;
        if (addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr got=%h exp=0", addr);
        end
        apply_reset();
    endtask

    task automatic test_streaming();
        cycle(1'b1, 1'b0, '0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'h0) begin
            errors++; $display("FAIL stream_first got v=%0b pc=%h data=%h exp v=1 pc=0 data=0", instr_valid, instr_pc, instr_data);
        end
        for (int k = 1; k < 10; k++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instr_data !== 32'(k)
                || addr !== 32'(k * 4 + 4)) begin
                errors++;
                $display("FAIL stream_%0d got v=%0b pc=%h data=%h addr=%h exp pc=%h data=%h addr=%h",
                         k, instr_valid, instr_pc, instr_data, addr, 32'(k * 4), 32'(k), 32'(k * 4 + 4));
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        repeat (10) cycle(1'b0, 1'b0, '0);
        checks++;
        if (addr !== 32'h10 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL full_hold got addr=%h v=%0b pc=%h exp addr=10 v=1 pc=0", addr, instr_valid, instr_pc);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instr_data !== 32'(k)) begin
                errors++; $display("FAIL drain_%0d got v=%0b pc=%h data=%h exp pc=%h data=%h",
                                   k, instr_valid, instr_pc, instr_data, 32'(k * 4), 32'(k));
            end
            cycle(1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_redirect_full();
        logic [31:0] head_pc;
        repeat (6) cycle(1'b0, 1'b0, '0);
        head_pc = instr_pc;
        cycle(1'b1, 1'b1, 32'h0000_0103);
        checks++;
        if (instr_valid !== 1'b0 || addr !== 32'h100 || instr_data !== NOP || instr_pc !== 32'h0) begin
            errors++; $display("FAIL redir_flush got v=%0b addr=%h data=%h pc=%h (old head %h) exp v=0 addr=100",
                               instr_valid, addr, instr_data, instr_pc, head_pc);
        end
        cycle(1'b0, 1'b0, '0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== 32'h40) begin
            errors++; $display("FAIL redir_first got v=%0b pc=%h data=%h exp v=1 pc=100 data=40", instr_valid, instr_pc, instr_data);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k] || instr_data !== rom(exp_pc[k])) begin
                errors++; $display("FAIL wrap_%0d got v=%0b pc=%h data=%h exp pc=%h data=%h",
                                   k, instr_valid, instr_pc, instr_data, exp_pc[k], rom(exp_pc[k]));
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (3) cycle(1'b0, 1'b0, '0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || addr !== 32'h0 || instr_data !== NOP) begin
            errors++; $display("FAIL async_reset got v=%0b addr=%h data=%h exp v=0 addr=0 data=%h", instr_valid, addr, instr_data, NOP);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_pc = 32'h0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, '0);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4)) begin
                errors++; $display("FAIL async_restart_%0d got v=%0b pc=%h exp pc=%h", k, instr_valid, instr_pc, 32'(k * 4));
            end
        end
    endtask

    task automatic test_random();
        logic        rdy, rv;
        logic [31:0] rpc, next_pc;
        logic [31:0] e_data, e_pc;
        cycle(1'b0, 1'b1, 32'h0000_2000);
        next_pc = 32'h0000_2000;
        for (int n = 0; n < 300; n++) begin
            e_pc   = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
            e_data = (mq.size() != 0) ? mq[0][31:0]  : NOP;
            checks++;
            if (instr_valid !== (mq.size() != 0) || instr_pc !== e_pc || instr_data !== e_data || addr !== m_pc) begin
                errors++; $display("FAIL rand_model_%0d got v=%0b pc=%h data=%h addr=%h exp v=%0b pc=%h data=%h addr=%h",
                                   n, instr_valid, instr_pc, instr_data, addr, (mq.size() != 0), e_pc, e_data, m_pc);
            end
            rdy = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            if (!rv && rdy && instr_valid) begin
                checks++;
                if (instr_pc !== next_pc) begin
                    errors++; $display("FAIL rand_seq_%0d got pc=%h exp pc=%h", n, instr_pc, next_pc);
                end
                next_pc = next_pc + 32'd4;
            end
            if (rv) next_pc = {rpc[31:2], 2'b00};
            cycle(rdy, rv, rpc);
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        m_pc           = 32'h0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32e_fetch_buffer.md
# rv32e_fetch_buffer

Instruction prefetch stage between the program ROM and the rv32e_cpu decode stage. Owns the fetch PC, drives the ROM address bus, and captures returned words into a small FIFO that decode drains with a valid/ready handshake. A redirect (branch/jump/trap target) flushes the queue and restarts fetch at the new PC. Throughput is one instruction per cycle while decode keeps up.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: fetch address after reset; word-aligned.

- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_program_addr_bus  out  32  ROM word address (byte address, bits[1:0]=0).
- mem_program_data_bus  in  32  ROM read data. Combinational, valid in the same cycle as the address.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr_data  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC.

## Operation
- Registers: fetch_pc (32), FIFO storage of {pc, data} × DEPTH, rd_ptr/wr_ptr (log2 DEPTH), count (log2 DEPTH + 1).
- Address bus: mem_program_addr_bus = fetch_pc, combinational from the register.
- pop = instr_valid & instr_ready & ~redirect_valid.
- push = ~redirect_valid & (count < DEPTH | pop). On push, write {fetch_pc, mem_program_data_bus} at wr_ptr and set fetch_pc ← fetch_pc + 4.
- count update: +1 on push only, −1 on pop only, unchanged when both or neither occur. Pointers wrap modulo DEPTH.
- Redirect has priority over everything in that cycle:
  - count, rd_ptr and wr_ptr are cleared.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}. Misaligned low bits are silently dropped.
  - No push and no pop occur. The head presented that cycle is not consumed, even if instr_ready=1.
- Output mux:
  - count ≠ 0: instr_valid=1, instr_data/instr_pc = entry at rd_ptr.
  - count = 0: instr_valid=0, instr_data=32'h0000_0013 (NOP), instr_pc=32'h0.
- fetch_pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No exception is raised.
- Full with no pop: fetch_pc holds and the ROM address stays stable. Nothing is lost or refetched.

## Timing
- Reset asserted (async) forces:
  - fetch_pc = RESET_PC, so mem_program_addr_bus = RESET_PC.
  - count = 0, pointers = 0.
  - instr_valid = 0, instr_data = NOP, instr_pc = 0.
  - FIFO storage contents are don't-care.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
- The first rising edge after reset release pushes ROM[RESET_PC]. instr_valid rises in the following cycle (1-cycle fetch latency).
- Fetch-to-valid latency is 1 cycle. Redirect-to-valid latency is 2 edges: the redirect edge, then the push edge.
- Full FIFO with instr_ready=1: push and pop happen on the same edge and count stays DEPTH.
- Empty FIFO with instr_ready=1: no pop. The push proceeds normally.
- instr_data and instr_pc are register outputs with no combinational path from instr_ready. Only the redirect gating of pop is combinational.

## Structure
- Shared package rv32e_pkg holds:
  - XLEN = 32.
  - RV32E_RESET_PC.
  - RV32E_NOP = 32'h0000_0013.
  - typedef fetch_entry_t {pc[31:0], data[31:0]}.
- Sub-module rv32e_instr_fifo: generic synchronous FIFO with push, pop, flush, full, empty and count, parameterised by DEPTH and entry width. The top level keeps fetch_pc, the push/pop/redirect logic and the output mux.

## Test plan
- **Reset and streaming:** ROM word n = n, instr_ready=1, release reset → instr_valid rises after 1 edge; instr_pc sequence 0,4,8,… with data 0,1,2,… one per cycle; addr_bus leads instr_pc by 4.
- **Backpressure/full:** hold instr_ready=0 for 10 cycles → count saturates at 4, addr_bus frozen at 32'h10. Then instr_ready=1 → entries pc 0..C delivered in order, followed by pc 0x10 with no gap and no duplicate.
- **Redirect with full queue:** redirect_valid=1, redirect_pc=32'h0000_0103 while instr_ready=1 → that head is not consumed; next cycle instr_valid=0, addr_bus=32'h100; the cycle after, instr_pc=32'h100.
- **Wrap-around:** redirect to 32'hFFFF_FFF8 → instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Async reset mid-stream:** assert reset between clock edges with count=3 → instr_valid=0 and addr_bus=RESET_PC immediately; after release, stream restarts at pc 0.
- **Simultaneous push/pop at count=1 with toggling instr_ready:** randomised instr_ready → delivered pc sequence strictly +4 with none skipped, compared against a scoreboard.
